// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: request owner,
// access-size codes and the fetch starvation-guard FSM states.
package mem_arb_pkg;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } starve_st_e;

endpackage

// File: rtl/arb_tag_pipe.sv
// In-flight read tag pipeline: DEPTH-stage shift register of {valid, owner};
// the last stage lines up with the memory read data of the matching access.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_valid,
  input  logic i_owner,
  output logic o_valid,
  output logic o_owner
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_own;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_own[0] <= i_owner;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_owner = r_own[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (read-only) and data (read/write).
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              o_dbg_force
);

  logic w_force;
  logic w_push_valid;
  logic w_push_owner;
  logic w_tag_valid;
  logic w_tag_owner;

`ifdef ARB_STARVE_GUARD_EN
  starve_st_e r_state;
  logic [2:0] r_starve;
  logic [2:0] w_starve_nxt;

  always_comb begin
    w_starve_nxt = r_starve;
    if (if_gnt)
      w_starve_nxt = 3'd0;
    else if (if_req && r_starve != 3'd7)
      w_starve_nxt = r_starve + 3'd1;
  end

  // FORCE lasts exactly one cycle, entered as soon as the count reaches STARVE_MAX.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_NORMAL;
      r_starve <= 3'd0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          r_starve <= w_starve_nxt;
          if (w_starve_nxt >= 3'(STARVE_MAX))
            r_state <= ST_FORCE;
        end
        default: begin
          r_state  <= ST_NORMAL;
          r_starve <= 3'd0;
        end
      endcase
    end
  end

  assign w_force = (r_state == ST_FORCE);
`else
  logic [2:0] w_unused_starve;
  assign w_unused_starve = 3'(STARVE_MAX);
  assign w_force         = 1'b0;
`endif

  assign o_dbg_force = w_force;

  // Handshake: a requester holds req and its fields until gnt; gnt is combinational
  // and the transaction is accepted on the clock edge where req & gnt.
  assign d_gnt  = ~reset & d_req & ~w_force;
  assign if_gnt = ~reset & if_req & (w_force | ~d_req);

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_size  = SZ_WORD;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_size  = d_size;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  assign w_push_valid = if_gnt | (d_gnt & ~d_we);
  assign w_push_owner = d_gnt ? OWN_DATA : OWN_FETCH;

  arb_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .i_valid (w_push_valid),
    .i_owner (w_push_owner),
    .o_valid (w_tag_valid),
    .o_owner (w_tag_owner)
  );

  assign if_rvalid = ~reset & w_tag_valid & (w_tag_owner == OWN_FETCH);
  assign d_rvalid  = ~reset & w_tag_valid & (w_tag_owner == OWN_DATA);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1..3) share one stimulus
// stream and are checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NI   = 3;
  localparam int SMAX = 4;

  // ---------------- clock / reset / DUT signals ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] mem_rdata;

  logic [NI-1:0] if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [NI-1:0] mem_en_o, mem_we_o, dbg_force_o;
  logic [DW-1:0] if_rdata_o [NI];
  logic [DW-1:0] d_rdata_o  [NI];
  logic [1:0]    mem_size_o [NI];
  logic [AW-1:0] mem_addr_o [NI];
  logic [DW-1:0] mem_wdata_o[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g + 1), .STARVE_MAX(SMAX)
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt_o[g]),
      .if_rvalid  (if_rvalid_o[g]),
      .if_rdata   (if_rdata_o[g]),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_size     (d_size),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt_o[g]),
      .d_rvalid   (d_rvalid_o[g]),
      .d_rdata    (d_rdata_o[g]),
      .mem_en     (mem_en_o[g]),
      .mem_we     (mem_we_o[g]),
      .mem_size   (mem_size_o[g]),
      .mem_addr   (mem_addr_o[g]),
      .mem_wdata  (mem_wdata_o[g]),
      .mem_rdata  (mem_rdata),
      .o_dbg_force(dbg_force_o[g])
    );
  end

  // ---------------- scoreboard / reference model state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  // entry = {due cycle[31:0], latency[2:0], owner}
  logic [35:0] exp_q[$];
  int          starve_cnt = 0;
  logic        got_if, got_d;
  int          if_gnt_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fetch(input logic req, input logic [AW-1:0] addr);
    if_req  = req;
    if_addr = addr;
  endtask

  task automatic drive_data(input logic req, input logic we, input logic [1:0] size,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    d_req   = req;
    d_we    = we;
    d_size  = size;
    d_addr  = addr;
    d_wdata = wdata;
  endtask

  // One clock cycle: check all instances at the falling edge, update the model,
  // then step past the rising edge and present fresh memory read data.
  task automatic cycle(input string tag);
    logic        force_now, e_if, e_d, e_rd;
    logic        hit;
    logic        own;
    logic [35:0] keep_q[$];
    @(negedge clock);
`ifdef ARB_STARVE_GUARD_EN
    force_now = !reset && (starve_cnt >= SMAX);
`else
    force_now = 1'b0;
`endif
    e_d  = !reset && d_req && !force_now;
    e_if = !reset && if_req && (force_now || !d_req);
    e_rd = e_if || (e_d && !d_we);
    if (reset) exp_q.delete();

    for (int g = 0; g < NI; g++) begin
      string t;
      t = $sformatf("%s/L%0d", tag, g + 1);
      chk({t, "/if_gnt"}, 64'(if_gnt_o[g]), 64'(e_if));
      chk({t, "/d_gnt"},  64'(d_gnt_o[g]),  64'(e_d));
      chk({t, "/mem_en"}, 64'(mem_en_o[g]), 64'(e_if || e_d));
      chk({t, "/mem_we"}, 64'(mem_we_o[g]), 64'(e_d && d_we));
      chk({t, "/force"},  64'(dbg_force_o[g]), 64'(force_now));
      if (e_d || e_if) begin
        chk({t, "/mem_addr"}, 64'(mem_addr_o[g]), 64'(e_d ? d_addr : if_addr));
        chk({t, "/mem_size"}, 64'(mem_size_o[g]), 64'(e_d ? d_size : SZ_WORD));
      end
      if (e_d && d_we) chk({t, "/mem_wdata"}, 64'(mem_wdata_o[g]), 64'(d_wdata));

      hit = 1'b0;
      own = 1'b0;
      foreach (exp_q[k]) begin
        if (exp_q[k][35:4] == cyc && exp_q[k][3:1] == 3'(g + 1)) begin
          hit = 1'b1;
          own = exp_q[k][0];
        end
      end
      chk({t, "/if_rvalid"}, 64'(if_rvalid_o[g]), 64'(hit && own == OWN_FETCH));
      chk({t, "/d_rvalid"},  64'(d_rvalid_o[g]),  64'(hit && own == OWN_DATA));
      if (hit && own == OWN_FETCH) chk({t, "/if_rdata"}, 64'(if_rdata_o[g]), 64'(mem_rdata));
      if (hit && own == OWN_DATA)  chk({t, "/d_rdata"},  64'(d_rdata_o[g]),  64'(mem_rdata));
    end

    foreach (exp_q[k]) if (exp_q[k][35:4] > cyc) keep_q.push_back(exp_q[k]);
    exp_q = keep_q;
    if (e_rd)
      for (int g = 0; g < NI; g++)
        exp_q.push_back({32'(cyc + g + 1), 3'(g + 1), (e_d ? OWN_DATA : OWN_FETCH)});

    if (reset || force_now || e_if) starve_cnt = 0;
    else if (if_req && starve_cnt < 7) starve_cnt++;
    got_if = e_if;
    got_d  = e_d;
    if (e_if) if_gnt_count++;

    @(posedge clock);
    #1;
    cyc++;
    mem_rdata = $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    mem_rdata = $urandom;
    drive_fetch(1'b0, '0);
    drive_data(1'b0, 1'b0, SZ_WORD, '0, '0);
    @(posedge clock);
    #1;
    repeat (2) cycle("reset");
    reset = 1'b0;
    cycle("idle");

    // single fetch, response one cycle later on the MEM_LAT=1 instance
    drive_fetch(1'b1, 32'h0100_0000);
    cycle("fetch");
    drive_fetch(1'b0, '0);
    cycle("fetch_resp");
    cycle("fetch_drain");

    // simultaneous requests: data read wins
    drive_fetch(1'b1, 32'h0100_0004);
    drive_data(1'b1, 1'b0, SZ_WORD, 32'h0100_0100, '0);
    cycle("collide");
    drive_data(1'b0, 1'b0, SZ_WORD, '0, '0);
    cycle("collide_fetch");
    drive_fetch(1'b0, '0);
    repeat (3) cycle("collide_drain");

    // byte write: no response
    drive_data(1'b1, 1'b1, SZ_BYTE, 32'h0100_0200, 32'h0000_00AB);
    cycle("write");
    drive_data(1'b0, 1'b0, SZ_WORD, '0, '0);
    repeat (3) cycle("write_drain");

    // alternating fetch/data reads, fully pipelined
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        drive_fetch(1'b1, 32'h0100_1000 + 32'(i * 4));
        drive_data(1'b0, 1'b0, SZ_WORD, '0, '0);
      end else begin
        drive_fetch(1'b0, '0);
        drive_data(1'b1, 1'b0, SZ_HALF, 32'h0100_2000 + 32'(i * 2), '0);
      end
      cycle("alt");
    end
    drive_fetch(1'b0, '0);
    drive_data(1'b0, 1'b0, SZ_WORD, '0, '0);
    repeat (4) cycle("alt_drain");

    // starvation: data held for 10 cycles against a waiting fetch
    reset = 1'b1;
    cycle("starve_rst");
    reset = 1'b0;
    if_gnt_count = 0;
    drive_fetch(1'b1, 32'h0100_3000);
    drive_data(1'b1, 1'b0, SZ_WORD, 32'h0100_4000, '0);
    for (int i = 1; i <= 10; i++) cycle($sformatf("starve%0d", i));
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_gnts", 64'(if_gnt_count), 64'd2);
`else
    chk("starve_gnts", 64'(if_gnt_count), 64'd0);
`endif
    drive_fetch(1'b0, '0);
    drive_data(1'b0, 1'b0, SZ_WORD, '0, '0);
    repeat (4) cycle("starve_drain");

    // reset one cycle after a read grant drops the in-flight response
    drive_fetch(1'b1, 32'h0100_5000);
    cycle("rst_grant");
    drive_fetch(1'b0, '0);
    reset = 1'b1;
    cycle("rst_mid");
    reset = 1'b0;
    repeat (4) cycle("rst_after");

    // randomized traffic honouring the hold-until-grant handshake
    got_if = 1'b1;
    got_d  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!if_req || got_if)
        drive_fetch($urandom_range(0, 1) == 1, {$urandom_range(0, 255), 2'b00});
      if (!d_req || got_d)
        drive_data($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   2'($urandom_range(0, 2)), $urandom, $urandom);
      reset = ($urandom_range(0, 60) == 0);
      cycle("rand");
    end
    reset = 1'b0;
    drive_fetch(1'b0, '0);
    drive_data(1'b0, 1'b0, SZ_WORD, '0, '0);
    repeat (4) cycle("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
